// File: rtl/step_clk_ctrl_if.sv
// -----------------------------------------------------------------------------
// step_clk_ctrl_if
// Groups the board-facing signals of the processor clock-enable controller.
//   master : board/test side; drives the raw button and mode switch, observes
//            the enable strobe and status outputs.
//   slave  : the controller itself.
// Signals:
//   key_n      raw push-button, active-low, asynchronous to clk
//   run_sw     raw mode switch (1 = free run, 0 = single step), asynchronous
//   cpu_en     one-clock-wide (STEP) or continuous (RUN) processor enable
//   running    high while free-running (LED)
//   key_db     debounced button state, 1 = pressed
//   step_count number of clk edges sampled with cpu_en = 1 (wraps)
// -----------------------------------------------------------------------------
interface step_clk_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             key_n;
  logic             run_sw;
  logic             cpu_en;
  logic             running;
  logic             key_db;
  logic [CNT_W-1:0] step_count;

  modport master (
    output key_n,
    output run_sw,
    input  cpu_en,
    input  running,
    input  key_db,
    input  step_count
  );

  modport slave (
    input  key_n,
    input  run_sw,
    output cpu_en,
    output running,
    output key_db,
    output step_count
  );
endinterface

// File: rtl/step_clk_ctrl.sv
// -----------------------------------------------------------------------------
// step_clk_ctrl
// Clock-enable controller for a soft-core processor. Turns a bouncing push
// button into exactly one single-cycle cpu_en pulse per debounced press, and a
// mode switch into a continuous free-run enable.
// Ports:
//   clk    board clock, the only clock of the block
//   reset  asynchronous, active-high reset
//   bus    step_clk_ctrl_if.slave (key_n, run_sw in; cpu_en, running,
//          key_db, step_count out)
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable synchronised cycles needed to accept
//                    a button level change (>= 2)
//   CNT_W            width of step_count
// -----------------------------------------------------------------------------
module step_clk_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 32
) (
  input  logic            clk,
  input  logic            reset,
  step_clk_ctrl_if.slave  bus
);

  localparam int             DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_HOLD = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  // Synchronisers
  logic key_meta_q, key_meta_d;
  logic key_s_q,    key_s_d;
  logic run_meta_q, run_meta_d;
  logic run_s_q,    run_s_d;

  // Debouncer
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            key_db_q, key_db_d;
  logic            key_db_dly_q, key_db_dly_d;
  logic            press;

  // Control
  state_t           state_q, state_d;
  logic [CNT_W-1:0] step_count_q, step_count_d;
  logic             cpu_en;

  // ---------------------------------------------------------------------------
  // Next-state logic for synchronisers and debouncer
  // ---------------------------------------------------------------------------
  always_comb begin
    key_meta_d   = bus.key_n;
    key_s_d      = key_meta_q;
    run_meta_d   = bus.run_sw;
    run_s_d      = run_meta_q;
    key_db_dly_d = key_db_q;

    // Counter only advances while the synchronised (pressed-high) level
    // disagrees with the accepted level; any agreement restarts the window.
    key_db_d = key_db_q;
    db_cnt_d = '0;
    if (~key_s_q != key_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        key_db_d = ~key_s_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Rising edge of the debounced level: one cycle per accepted press.
  assign press = key_db_q & ~key_db_dly_q;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        // Mode switch wins over a coincident press.
        if (run_s_q)    state_d = S_RUN;
        else if (press) state_d = S_STEP;
      end
      S_STEP: state_d = S_HOLD;
      S_HOLD: if (!key_db_q) state_d = S_IDLE;
      S_RUN:  if (!run_s_q)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs straight from the state register, so an asynchronous
  // reset drops cpu_en without waiting for a clock edge.
  assign cpu_en = (state_q == S_STEP) || (state_q == S_RUN);

  always_comb begin
    step_count_d = step_count_q;
    if (cpu_en) step_count_d = step_count_q + CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta_q   <= 1'b1;
      key_s_q      <= 1'b1;
      run_meta_q   <= 1'b0;
      run_s_q      <= 1'b0;
      db_cnt_q     <= '0;
      key_db_q     <= 1'b0;
      key_db_dly_q <= 1'b0;
      state_q      <= S_IDLE;
      step_count_q <= '0;
    end else begin
      key_meta_q   <= key_meta_d;
      key_s_q      <= key_s_d;
      run_meta_q   <= run_meta_d;
      run_s_q      <= run_s_d;
      db_cnt_q     <= db_cnt_d;
      key_db_q     <= key_db_d;
      key_db_dly_q <= key_db_dly_d;
      state_q      <= state_d;
      step_count_q <= step_count_d;
    end
  end

  assign bus.cpu_en     = cpu_en;
  assign bus.running    = (state_q == S_RUN);
  assign bus.key_db     = key_db_q;
  assign bus.step_count = step_count_q;

endmodule

// File: tb/tb_step_clk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_step_clk_ctrl
// Two controller instances (32-bit and 4-bit step counters) share one clock,
// reset and stimulus. A behavioural model tracks the expected outputs and is
// compared on every falling edge; directed phases add hand-derived literal
// timing expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_step_clk_ctrl;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_n = 1'b1;
  logic run_sw = 1'b0;

  always #5 clk = ~clk;

  step_clk_ctrl_if #(.CNT_W(32)) bus_a ();
  step_clk_ctrl_if #(.CNT_W(4))  bus_b ();

  assign bus_a.key_n  = key_n;
  assign bus_a.run_sw = run_sw;
  assign bus_b.key_n  = key_n;
  assign bus_b.run_sw = run_sw;

  step_clk_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(32)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  step_clk_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: sync pipelines as shift lists, debounce as a run-length
  // of disagreement, and the controller as three mode flags.
  // ---------------------------------------------------------------------------
  bit         mk1, mk2, mr1, mr2;
  bit         m_db, m_db_prev;
  int         m_run_len;
  bit         m_run, m_step, m_hold;
  bit  [31:0] m_sc;

  task automatic model_reset();
    mk1 = 1; mk2 = 1; mr1 = 0; mr2 = 0;
    m_db = 0; m_db_prev = 0; m_run_len = 0;
    m_run = 0; m_step = 0; m_hold = 0;
    m_sc = 0;
  endtask

  task automatic model_edge();
    bit en_old, press_old;
    en_old    = m_run | m_step;
    press_old = m_db & ~m_db_prev;
    // controller mode
    if (m_run)       m_run = mr2;
    else if (m_step) begin m_step = 0; m_hold = 1; end
    else if (m_hold) m_hold = m_db;
    else if (mr2)    m_run = 1;
    else if (press_old) m_step = 1;
    m_sc = m_sc + (en_old ? 32'd1 : 32'd0);
    // debounce: accept after D consecutive disagreeing cycles
    m_db_prev = m_db;
    if ((!mk2) != m_db) begin
      m_run_len++;
      if (m_run_len == D) begin m_db = !mk2; m_run_len = 0; end
    end else begin
      m_run_len = 0;
    end
    mk2 = mk1; mk1 = key_n;
    mr2 = mr1; mr1 = run_sw;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_edge();
      if (clk) cyc++;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare plus event bookkeeping for the literal checks
  // ---------------------------------------------------------------------------
  int pulse_cnt = 0, last_pulse = -1;
  int run_rise = -1, run_fall = -1, db_rise = -1, db_fall = -1, db_rise_cnt = 0;
  bit prev_run = 0, prev_db = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("cpu_en_a",     {31'd0, bus_a.cpu_en},  {31'd0, m_run | m_step});
      chk("running_a",    {31'd0, bus_a.running}, {31'd0, m_run});
      chk("key_db_a",     {31'd0, bus_a.key_db},  {31'd0, m_db});
      chk("step_count_a", bus_a.step_count,       m_sc);
      chk("cpu_en_b",     {31'd0, bus_b.cpu_en},  {31'd0, m_run | m_step});
      chk("step_count_b", {28'd0, bus_b.step_count}, {28'd0, m_sc[3:0]});
      if (bus_a.cpu_en && !bus_a.running) begin pulse_cnt++; last_pulse = cyc; end
      if (bus_a.running && !prev_run) run_rise = cyc;
      if (!bus_a.running && prev_run) run_fall = cyc;
      if (bus_a.key_db && !prev_db) begin db_rise = cyc; db_rise_cnt++; end
      if (!bus_a.key_db && prev_db) db_fall = cyc;
      prev_run = bus_a.running;
      prev_db  = bus_a.key_db;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus (inputs change on falling edges)
  // ---------------------------------------------------------------------------
  int e0, p0, d0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cpu_en",  {31'd0, bus_a.cpu_en},  32'd0);
    chk("rst_running", {31'd0, bus_a.running}, 32'd0);
    chk("rst_key_db",  {31'd0, bus_a.key_db},  32'd0);
    chk("rst_count",   bus_a.step_count,       32'd0);
    reset = 0;
    repeat (5) @(negedge clk);

    // Single clean press: key_db at edge D+1, STEP at edge D+2
    key_n = 0; e0 = cyc + 1; p0 = pulse_cnt;
    repeat (20) @(negedge clk);
    chk("press_db_edge",    db_rise - e0,         32'd5);
    chk("press_step_edge",  last_pulse - e0,      32'd6);
    chk("press_pulses",     pulse_cnt - p0,       32'd1);
    key_n = 1; e0 = cyc + 1;
    repeat (12) @(negedge clk);
    chk("release_db_edge",  db_fall - e0,         32'd5);
    chk("press_count",      bus_a.step_count,     32'd1);

    // Bounce: low 3 / high 1 / low 2 / high, never long enough
    d0 = db_rise_cnt; p0 = pulse_cnt;
    key_n = 0; repeat (3) @(negedge clk);
    key_n = 1; repeat (1) @(negedge clk);
    key_n = 0; repeat (2) @(negedge clk);
    key_n = 1; repeat (12) @(negedge clk);
    chk("bounce_db_rises",  db_rise_cnt - d0,     32'd0);
    chk("bounce_pulses",    pulse_cnt - p0,       32'd0);
    chk("bounce_count",     bus_a.step_count,     32'd1);

    // Three clean presses
    p0 = pulse_cnt;
    for (int i = 0; i < 3; i++) begin
      key_n = 0; repeat (10) @(negedge clk);
      key_n = 1; repeat (10) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("three_pulses",     pulse_cnt - p0,       32'd3);
    chk("three_count",      bus_a.step_count,     32'd4);

    // Free run for 100 cycles, with a press in the middle that must be ignored
    p0 = pulse_cnt;
    run_sw = 1; e0 = cyc + 1;
    repeat (30) @(negedge clk);
    key_n = 0; repeat (10) @(negedge clk);
    key_n = 1; repeat (60) @(negedge clk);
    chk("run_rise_edge",    run_rise - e0,        32'd2);
    run_sw = 0; e0 = cyc + 1;
    repeat (10) @(negedge clk);
    chk("run_fall_edge",    run_fall - e0,        32'd2);
    chk("run_count",        bus_a.step_count,     32'd104);
    chk("run_count_wrap4",  {28'd0, bus_b.step_count}, 32'd8);
    chk("run_no_pulses",    pulse_cnt - p0,       32'd0);

    // Asynchronous reset in the middle of RUN
    run_sw = 1;
    repeat (10) @(negedge clk);
    @(posedge clk); #2 reset = 1; #1;
    chk("arst_run_cpu_en",  {31'd0, bus_a.cpu_en},  32'd0);
    chk("arst_run_running", {31'd0, bus_a.running}, 32'd0);
    chk("arst_run_count",   bus_a.step_count,       32'd0);
    run_sw = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (8) @(negedge clk);

    // Asynchronous reset while in HOLD; key still held gives one step at D+2
    key_n = 0;
    repeat (12) @(negedge clk);
    @(posedge clk); #2 reset = 1; #1;
    chk("arst_hold_cpu_en", {31'd0, bus_a.cpu_en}, 32'd0);
    chk("arst_hold_key_db", {31'd0, bus_a.key_db}, 32'd0);
    repeat (2) @(negedge clk);
    p0 = pulse_cnt;
    reset = 0; e0 = cyc + 1;
    repeat (14) @(negedge clk);
    chk("held_step_edge",   last_pulse - e0,      32'd6);
    chk("held_pulses",      pulse_cnt - p0,       32'd1);
    chk("held_count",       bus_a.step_count,     32'd1);
    key_n = 1;
    repeat (10) @(negedge clk);

    // Randomized phase
    for (int s = 0; s < 250; s++) begin
      key_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) run_sw = ~run_sw;
      repeat ($urandom_range(1, 14)) @(negedge clk);
    end
    key_n = 1; run_sw = 0;
    repeat (20) @(negedge clk);
    chk("final_running",    {31'd0, bus_a.running}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
